qcs_gpio_event_capture: RTL and testbench
=========================================

Name: qcs_gpio_event_capture

Overview:
- Synthesizable GPIO input front-end on the DUT side of the GPIO pins.
- Synchronizes and debounces the raw pins, then detects per-bit set (0->1) and clear (1->0) transitions.
- Queues each transition as an event record {set, clear, raw} in a small FIFO with a valid/ready output.
- Event semantics match the GPIO monitor transaction, so scoreboards compare them directly.

Parameters:
- WIDTH, 8: number of GPIO bits; legal range 1..32; elaboration fatal outside this range.
- SYNC_STAGES, 2: synchronizer flops per bit; legal value is 2 or more.
- DEBOUNCE_CYCLES, 4: number of consecutive cycles a new level must persist before it is accepted; legal value is 1 or more; 1 means no filtering.
- FIFO_DEPTH, 4: number of event entries; power of two, 2 or more.

Ports:
- clk, input, 1: single clock; all logic is on its rising edge.
- rst_n, input, 1: reset, asynchronous assert, active-low.
- gpio_in, input, WIDTH: asynchronous pin levels.
- en, input, 1: event enable; while low, no events are pushed.
- evt_valid, output, 1: FIFO head is valid.
- evt_ready, input, 1: consumer accepts the head.
- evt_set, output, WIDTH: bits that rose in this event.
- evt_clear, output, WIDTH: bits that fell in this event.
- evt_raw, output, WIDTH: filtered GPIO value after the event.
- gpio_filt, output, WIDTH: current debounced value.
- ovf, output, 1: sticky overflow flag.
- ovf_clr, input, 1: synchronous clear of ovf.
- fifo_level, output, $clog2(FIFO_DEPTH+1): current number of entries.

Behaviour:
- Reset: asynchronous, active-low, and may assert at any time, including mid-event or mid-debounce. Reset clears all of the following:
  - sync flops, debounce counters, gpio_filt, primed, FIFO pointers;
  - evt_valid, evt_set, evt_clear, evt_raw, ovf and fifo_level, which all go to 0.
  - Partial debounce progress is discarded.
- Synchronizer: a per-bit chain of SYNC_STAGES flops; sync = last stage.
- Priming: primed is 0 out of reset.
  - On the SYNC_STAGES-th rising edge after reset deassertion: gpio_filt <= sync, primed <= 1, no event pushed.
  - The debounce counters stay idle until primed is 1.
  - Pins that are high at reset release therefore never produce a set event.
- Debounce, per bit i, once primed:
  - sync[i]==gpio_filt[i]: cnt[i] <= 0.
  - Otherwise, if cnt[i]==DEBOUNCE_CYCLES-1: commit[i], gpio_filt[i] <= sync[i], cnt[i] <= 0.
  - Otherwise: cnt[i] <= cnt[i]+1.
  - A glitch shorter than DEBOUNCE_CYCLES cycles resets the counter and produces no event.
- Event formation, on a cycle where any commit bit is set:
  - set = commit & sync; clear = commit & ~sync; raw = next gpio_filt.
  - All bits committing on the same edge merge into one event.
  - The record is pushed when en=1. When en=0 the record is discarded and gpio_filt still updates.
- Latency: the first rising edge that samples a new stable level counts as edge 1. The push happens on edge SYNC_STAGES+DEBOUNCE_CYCLES. With an empty FIFO, evt_valid is 1 in the following cycle (6 edges with default parameters).
- FIFO:
  - Show-ahead: evt_* reflect the head whenever evt_valid=1.
  - Pop occurs on an edge with evt_valid & evt_ready.
  - evt_set, evt_clear and evt_raw are stable while evt_valid=1 and evt_ready=0.
  - When evt_valid=0, evt_* hold their last value; the consumer must not interpret them.
  - fifo_level is updated on the same edge as the push or pop.
- Full FIFO:
  - A push with no simultaneous pop drops the new event and sets ovf.
  - A push with a simultaneous pop is accepted; level stays FIFO_DEPTH and ovf is unchanged.
- Empty FIFO: evt_ready is ignored and level stays 0. A push into an empty FIFO is visible in the next cycle; there is no bypass.
- ovf clearing: ovf_clr clears ovf. If an overflow occurs on the same edge as ovf_clr, ovf stays 1 (set wins).
- en toggle: takes effect on the same edge; events already queued are unaffected.

Test Plan:
1. Reset with gpio_in=8'hA5, defaults:
   - gpio_filt=8'hA5 after edge 2.
   - No event; fifo_level=0.
2. Bit0 0->1 held stable:
   - evt_valid=1 after edge 6.
   - Event is evt_set=8'h01, evt_clear=0, evt_raw=8'hA5|1.
   - evt_ready=1 pops it; level returns to 0.
3. Bit3 high for 3 cycles only:
   - No event; gpio_filt unchanged; debounce counter returns to 0.
4. Bits 7 and 1 toggle on the same cycle (1->0 and 0->1):
   - A single event with set=8'h02 and clear=8'h80.
5. evt_ready=0 with 5 separate edges:
   - Level reaches 4 and ovf=1.
   - The 5th event is dropped; the head is unchanged.
   - ovf_clr with a simultaneous 6th edge leaves ovf=1.
   - A full FIFO with pop and push on the same edge keeps level=4 and leaves ovf unchanged.
6. Assert rst_n mid-debounce (cnt=2) and with 2 entries queued:
   - evt_valid=0, fifo_level=0 and ovf=0 immediately (asynchronous).
   - After release, re-prime occurs with no spurious event.

Source files
------------

// File: rtl/qcs_gpio_event_capture.sv
// Purpose: GPIO input front-end; synchronizes, debounces and turns per-bit level changes into queued event records.
// Latency: push on edge SYNC_STAGES+DEBOUNCE_CYCLES after a pin change; evt_valid follows one cycle later (no bypass).
// Backpressure: evt_ready stalls the FIFO head; new events arriving at a full FIFO without a pop are dropped and flag ovf.
//
// Ports:
//   clk, rst_n        clock (rising edge) and asynchronous active-low reset
//   gpio_in           asynchronous pin levels
//   en                event enable; records formed while low are discarded
//   evt_valid/ready   valid/ready handshake for the event FIFO head
//   evt_set/clear/raw head record: rising bits, falling bits, filtered value after the event
//   gpio_filt         current debounced value
//   ovf, ovf_clr      sticky overflow flag and its synchronous clear (set wins)
//   fifo_level        number of queued entries

// Small show-ahead FIFO. A write into a full FIFO is accepted only when a
// read happens on the same edge.
module qcs_gpio_evt_fifo #(
  parameter int DW    = 24,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       wr_vld,
  output logic                       wr_rdy,
  input  logic [DW-1:0]              wr_dat,
  output logic                       rd_vld,
  input  logic                       rd_rdy,
  output logic [DW-1:0]              rd_dat,
  output logic [$clog2(DEPTH+1)-1:0] level
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = $clog2(DEPTH+1);

  logic [DW-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr_q;
  logic [AW-1:0] rd_ptr_q;
  logic [LW-1:0] level_q;
  logic          wr_en;
  logic          rd_en;

  assign rd_vld = (level_q != LW'(0));
  assign rd_en  = rd_vld && rd_rdy;
  assign wr_rdy = (level_q != LW'(DEPTH)) || rd_en;
  assign wr_en  = wr_vld && wr_rdy;
  assign rd_dat = mem[rd_ptr_q];
  assign level  = level_q;

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_ptr_q] <= wr_dat;
    end
  end

  // DEPTH is a power of two, so the pointers wrap naturally.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      if (wr_en) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (rd_en) rd_ptr_q <= rd_ptr_q + AW'(1);
      case ({wr_en, rd_en})
        2'b10:   level_q <= level_q + LW'(1);
        2'b01:   level_q <= level_q - LW'(1);
        default: level_q <= level_q;
      endcase
    end
  end

endmodule

module qcs_gpio_event_capture #(
  parameter int WIDTH           = 8,
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int FIFO_DEPTH      = 4
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic [WIDTH-1:0]                gpio_in,
  input  logic                            en,
  output logic                            evt_valid,
  input  logic                            evt_ready,
  output logic [WIDTH-1:0]                evt_set,
  output logic [WIDTH-1:0]                evt_clear,
  output logic [WIDTH-1:0]                evt_raw,
  output logic [WIDTH-1:0]                gpio_filt,
  output logic                            ovf,
  input  logic                            ovf_clr,
  output logic [$clog2(FIFO_DEPTH+1)-1:0] fifo_level
);

  localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam int PW = $clog2(SYNC_STAGES + 1);

  if (WIDTH < 1 || WIDTH > 32) begin : g_bad_width
    $fatal(1, "qcs_gpio_event_capture: WIDTH must be 1..32");
  end
  if (SYNC_STAGES < 2) begin : g_bad_sync
    $fatal(1, "qcs_gpio_event_capture: SYNC_STAGES must be >= 2");
  end
  if (DEBOUNCE_CYCLES < 1) begin : g_bad_deb
    $fatal(1, "qcs_gpio_event_capture: DEBOUNCE_CYCLES must be >= 1");
  end
  if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
    $fatal(1, "qcs_gpio_event_capture: FIFO_DEPTH must be a power of two >= 2");
  end

  typedef struct packed {
    logic [WIDTH-1:0] set_bits;
    logic [WIDTH-1:0] clear_bits;
    logic [WIDTH-1:0] raw_bits;
  } evt_t;

  // Synchronizer chain
  logic [SYNC_STAGES-1:0][WIDTH-1:0] sync_q;
  logic [WIDTH-1:0]                  sync;
  logic [WIDTH-1:0]                  sync_pre;

  assign sync     = sync_q[SYNC_STAGES-1];
  // Value the last stage is about to take; priming loads it so gpio_filt
  // matches the pins on the same edge the chain fills.
  assign sync_pre = sync_q[SYNC_STAGES-2];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '0;
    end else begin
      sync_q[0] <= gpio_in;
      for (int k = 1; k < SYNC_STAGES; k++) begin
        sync_q[k] <= sync_q[k-1];
      end
    end
  end

  // Priming: after the chain has filled, adopt its value without an event so
  // pins already high at reset release are not reported as rising.
  logic          primed_q;
  logic [PW-1:0] prime_cnt_q;
  logic          prime_now;

  assign prime_now = !primed_q && (prime_cnt_q == PW'(SYNC_STAGES - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      primed_q    <= 1'b0;
      prime_cnt_q <= '0;
    end else if (prime_now) begin
      primed_q <= 1'b1;
    end else if (!primed_q) begin
      prime_cnt_q <= prime_cnt_q + PW'(1);
    end
  end

  // Debounce
  logic [WIDTH-1:0] filt_q;
  logic [CW-1:0]    cnt_q [WIDTH];
  logic [WIDTH-1:0] diff;
  logic [WIDTH-1:0] commit;
  logic [WIDTH-1:0] filt_nxt;

  assign diff = primed_q ? (sync ^ filt_q) : '0;

  always_comb begin
    commit = '0;
    for (int i = 0; i < WIDTH; i++) begin
      if (diff[i] && (cnt_q[i] == CW'(DEBOUNCE_CYCLES - 1))) begin
        commit[i] = 1'b1;
      end
    end
  end

  assign filt_nxt = (filt_q & ~commit) | (sync & commit);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      filt_q <= '0;
      for (int i = 0; i < WIDTH; i++) begin
        cnt_q[i] <= '0;
      end
    end else if (prime_now) begin
      filt_q <= sync_pre;
    end else if (primed_q) begin
      filt_q <= filt_nxt;
      // Any sample back at the filtered level restarts the count, so a
      // glitch never accumulates across separate excursions.
      for (int i = 0; i < WIDTH; i++) begin
        if (!diff[i] || commit[i]) begin
          cnt_q[i] <= '0;
        end else begin
          cnt_q[i] <= cnt_q[i] + CW'(1);
        end
      end
    end
  end

  assign gpio_filt = filt_q;

  // Event formation: all bits committing together merge into one record.
  evt_t push_dat;
  logic push_vld;
  logic push_rdy;
  evt_t head_dat;
  evt_t last_q;
  logic head_vld;

  always_comb begin
    push_dat            = '0;
    push_dat.set_bits   = commit & sync;
    push_dat.clear_bits = commit & ~sync;
    push_dat.raw_bits   = filt_nxt;
  end

  assign push_vld = (|commit) && en;

  qcs_gpio_evt_fifo #(
    .DW    ($bits(evt_t)),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk    (clk),
    .rst_n  (rst_n),
    .wr_vld (push_vld),
    .wr_rdy (push_rdy),
    .wr_dat (push_dat),
    .rd_vld (head_vld),
    .rd_rdy (evt_ready),
    .rd_dat (head_dat),
    .level  (fifo_level)
  );

  // Sticky overflow; a drop on the same edge as the clear keeps it set.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovf <= 1'b0;
    end else if (push_vld && !push_rdy) begin
      ovf <= 1'b1;
    end else if (ovf_clr) begin
      ovf <= 1'b0;
    end
  end

  // Hold the last head shown so evt_* do not wander onto stale FIFO slots
  // once the queue drains.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_q <= '0;
    end else if (head_vld) begin
      last_q <= head_dat;
    end
  end

  assign evt_valid = head_vld;
  assign evt_set   = head_vld ? head_dat.set_bits   : last_q.set_bits;
  assign evt_clear = head_vld ? head_dat.clear_bits : last_q.clear_bits;
  assign evt_raw   = head_vld ? head_dat.raw_bits   : last_q.raw_bits;

endmodule

// File: tb/tb_qcs_gpio_event_capture.sv
// Purpose: directed self-checking bench for qcs_gpio_event_capture with default parameters.
// Latency: inputs change on the falling edge; outputs are sampled on the falling edge after N rising edges.
// Backpressure: evt_ready is driven explicitly per step to build up, pop and overflow the FIFO.
module tb_qcs_gpio_event_capture;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] gpio_in;
  logic       en;
  logic       evt_valid;
  logic       evt_ready;
  logic [7:0] evt_set;
  logic [7:0] evt_clear;
  logic [7:0] evt_raw;
  logic [7:0] gpio_filt;
  logic       ovf;
  logic       ovf_clr;
  logic [2:0] fifo_level;

  int tests = 0;
  int fails = 0;

  qcs_gpio_event_capture dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .gpio_in    (gpio_in),
    .en         (en),
    .evt_valid  (evt_valid),
    .evt_ready  (evt_ready),
    .evt_set    (evt_set),
    .evt_clear  (evt_clear),
    .evt_raw    (evt_raw),
    .gpio_filt  (gpio_filt),
    .ovf        (ovf),
    .ovf_clr    (ovf_clr),
    .fifo_level (fifo_level)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  // Advance n rising edges, ending on the following falling edge.
  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      @(negedge clk);
    end
  endtask

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    tests++;
    assert (observed === expected) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic check_head(input string tag, input logic [7:0] s, input logic [7:0] c, input logic [7:0] r);
    check({tag, ".valid"}, 32'(evt_valid), 32'd1);
    check({tag, ".set"},   32'(evt_set),   32'(s));
    check({tag, ".clear"}, 32'(evt_clear), 32'(c));
    check({tag, ".raw"},   32'(evt_raw),   32'(r));
  endtask

  // Drive a new pin value and wait the 6 edges after which its event is queued.
  task automatic edge_event(input logic [7:0] v);
    gpio_in = v;
    tick(6);
  endtask

  initial begin
    rst_n     = 1'b0;
    gpio_in   = 8'hA5;
    en        = 1'b1;
    evt_ready = 1'b0;
    ovf_clr   = 1'b0;
    tick(3);

    // 1. Reset state and priming with pins at A5
    check("rst.valid", 32'(evt_valid),  32'd0);
    check("rst.level", 32'(fifo_level), 32'd0);
    check("rst.ovf",   32'(ovf),        32'd0);
    check("rst.filt",  32'(gpio_filt),  32'h00);
    check("rst.set",   32'(evt_set),    32'h00);
    rst_n = 1'b1;
    tick(1);
    check("prime.edge1.filt", 32'(gpio_filt), 32'h00);
    tick(1);
    check("prime.edge2.filt", 32'(gpio_filt), 32'hA5);
    tick(8);
    check("prime.noevt.valid", 32'(evt_valid),  32'd0);
    check("prime.noevt.level", 32'(fifo_level), 32'd0);

    // 2. Bit0 is already high in A5: drop it first, then raise it again.
    gpio_in = 8'hA4;
    tick(5);
    check("fall0.edge5.valid", 32'(evt_valid), 32'd0);
    tick(1);
    check_head("fall0", 8'h00, 8'h01, 8'hA4);
    evt_ready = 1'b1;
    tick(1);
    evt_ready = 1'b0;
    check("fall0.pop.level", 32'(fifo_level), 32'd0);
    check("fall0.pop.valid", 32'(evt_valid),  32'd0);
    // Drained: outputs keep the last shown head
    check("fall0.hold.clear", 32'(evt_clear), 32'h01);

    gpio_in = 8'hA5;
    tick(5);
    check("rise0.edge5.valid", 32'(evt_valid), 32'd0);
    tick(1);
    check_head("rise0", 8'h01, 8'h00, 8'hA5);
    check("rise0.level", 32'(fifo_level), 32'd1);
    evt_ready = 1'b1;
    tick(1);
    // Empty FIFO ignores evt_ready
    tick(1);
    evt_ready = 1'b0;
    check("rise0.pop.level", 32'(fifo_level), 32'd0);

    // 3. Two 3-cycle glitches on bit3: neither may commit
    gpio_in = 8'hAD;
    tick(3);
    gpio_in = 8'hA5;
    tick(3);
    gpio_in = 8'hAD;
    tick(3);
    gpio_in = 8'hA5;
    tick(8);
    check("glitch.valid", 32'(evt_valid),  32'd0);
    check("glitch.level", 32'(fifo_level), 32'd0);
    check("glitch.filt",  32'(gpio_filt),  32'hA5);

    // 4. Bit7 falls and bit1 rises on the same cycle: one merged event
    edge_event(8'h27);
    check_head("merge", 8'h02, 8'h80, 8'h27);
    check("merge.level", 32'(fifo_level), 32'd1);
    evt_ready = 1'b1;
    tick(1);
    evt_ready = 1'b0;
    check("merge.pop.level", 32'(fifo_level), 32'd0);

    // en=0: record discarded, filter still follows
    en = 1'b0;
    edge_event(8'h37);
    tick(2);
    en = 1'b1;
    check("en0.valid", 32'(evt_valid), 32'd0);
    check("en0.filt",  32'(gpio_filt), 32'h37);

    // 5. Fill and overflow with evt_ready low (bit4 toggles)
    edge_event(8'h27);  // e1: clear 10
    edge_event(8'h37);  // e2: set 10
    edge_event(8'h27);  // e3
    edge_event(8'h37);  // e4
    check("full.level", 32'(fifo_level), 32'd4);
    check("full.ovf",   32'(ovf),        32'd0);
    edge_event(8'h27);  // e5 dropped
    check("ovf5.level", 32'(fifo_level), 32'd4);
    check("ovf5.ovf",   32'(ovf),        32'd1);
    check_head("ovf5.head", 8'h00, 8'h10, 8'h27);
    check("ovf5.filt", 32'(gpio_filt), 32'h27);

    // e6 dropped on the same edge ovf_clr is asserted: set wins
    gpio_in = 8'h37;
    tick(5);
    ovf_clr = 1'b1;
    tick(1);
    ovf_clr = 1'b0;
    check("ovf6.setwins", 32'(ovf),        32'd1);
    check("ovf6.level",   32'(fifo_level), 32'd4);
    ovf_clr = 1'b1;
    tick(1);
    ovf_clr = 1'b0;
    check("ovfclr.ovf", 32'(ovf), 32'd0);

    // e7 pushed on the same edge the head pops: level stays 4, ovf unchanged
    gpio_in = 8'h27;
    tick(5);
    evt_ready = 1'b1;
    tick(1);
    evt_ready = 1'b0;
    check("pushpop.level", 32'(fifo_level), 32'd4);
    check("pushpop.ovf",   32'(ovf),        32'd0);
    check_head("pushpop.head", 8'h10, 8'h00, 8'h37);

    // e8 dropped again so ovf is set going into reset
    edge_event(8'h37);
    check("ovf8.ovf", 32'(ovf), 32'd1);

    // Queue is e2,e3,e4,e7; pop two, leaving e4 at the head
    evt_ready = 1'b1;
    tick(2);
    evt_ready = 1'b0;
    check("drain2.level", 32'(fifo_level), 32'd2);
    check_head("drain2.head", 8'h10, 8'h00, 8'h37);

    // 6. Reset mid-debounce (bit5 change, counter at 2) with 2 entries queued
    gpio_in = 8'h17;
    tick(4);
    rst_n = 1'b0;
    #1;
    check("arst.valid", 32'(evt_valid),  32'd0);
    check("arst.level", 32'(fifo_level), 32'd0);
    check("arst.ovf",   32'(ovf),        32'd0);
    check("arst.filt",  32'(gpio_filt),  32'h00);
    check("arst.set",   32'(evt_set),    32'h00);
    tick(2);
    rst_n = 1'b1;
    tick(2);
    check("reprime.filt", 32'(gpio_filt), 32'h17);
    tick(8);
    check("reprime.valid", 32'(evt_valid),  32'd0);
    check("reprime.level", 32'(fifo_level), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
